// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_arb_pkg : shared encodings for the instruction-memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package imem_arb_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic PORT_F = 1'b0;
   localparam logic PORT_L = 1'b1;

   // Wide enough for a load value of MEM_LAT-1 with MEM_LAT up to 4
   localparam int LAT_CNT_W = 2;

   // Single requester wins outright; on a tie the port not served last wins
   function automatic logic pick_port(input logic req_f, input logic req_l,
                                      input logic last_port);
      if (req_f && req_l)
         return (last_port == PORT_L) ? PORT_F : PORT_L;
      else if (req_l)
         return PORT_L;
      else
         return PORT_F;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arb_lat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_arb_lat_counter : memory-latency down-counter, flags expiry at zero
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_arb_lat_counter
   import imem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam logic [LAT_CNT_W-1:0] c_load_val = LAT_CNT_W'(MEM_LAT - 1);

   logic [LAT_CNT_W-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (load)
         r_cnt <= c_load_val;
      else if (dec && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_arbiter : fetch/loader arbiter for a single-port instruction memory.
// Define IMEM_ARB_RR_EN for round-robin ties; otherwise fetch always wins.
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic              f_flush,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   logic [1:0]        r_state;
   logic              r_port;
   logic              r_flushed;
   logic              r_m_en;
   logic              r_m_we;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wdata;
   logic [DATA_W-1:0] r_cap;
   logic [DATA_W-1:0] r_f_hold;
   logic [DATA_W-1:0] r_l_hold;

   logic              w_gnt_any;
   logic              w_win;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_resp;
   logic              w_lat_expired;

`ifdef IMEM_ARB_RR_EN
   logic r_last;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_last <= PORT_L;
      else if (w_gnt_any)
         r_last <= w_win;
   end

   assign w_win = pick_port(f_req, l_req, r_last);
`else
   assign w_win = pick_port(f_req, l_req, PORT_L);
`endif

   // Reset is folded in so combinational outputs are quiet while it is held
   assign w_gnt_any   = reset && (r_state == IDLE) && (f_req || l_req);
   assign w_sel_we    = (w_win == PORT_L) ? l_we    : 1'b0;
   assign w_sel_addr  = (w_win == PORT_L) ? l_addr  : f_addr;
   assign w_sel_wdata = (w_win == PORT_L) ? l_wdata : '0;

   assign f_gnt   = w_gnt_any && (w_win == PORT_F);
   assign l_gnt   = w_gnt_any && (w_win == PORT_L);
   assign m_en    = w_gnt_any || r_m_en;
   assign m_we    = w_gnt_any ? w_sel_we    : r_m_we;
   assign m_addr  = w_gnt_any ? w_sel_addr  : r_m_addr;
   assign m_wdata = w_gnt_any ? w_sel_wdata : r_m_wdata;

   assign w_resp   = (r_state == RESP);
   assign f_rvalid = w_resp && (r_port == PORT_F) && !r_flushed && !f_flush;
   assign l_rvalid = w_resp && (r_port == PORT_L);
   assign f_rdata  = f_rvalid ? r_cap : r_f_hold;
   assign l_rdata  = l_rvalid ? r_cap : r_l_hold;
   assign busy     = (r_state != IDLE);

   imem_arb_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_cnt (
      .clock   (clock),
      .reset   (reset),
      .load    (w_gnt_any),
      .dec     (r_state == WAIT),
      .expired (w_lat_expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_port    <= PORT_F;
         r_flushed <= 1'b0;
         r_m_en    <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_cap     <= '0;
         r_f_hold  <= '0;
         r_l_hold  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_any) begin
                  r_state   <= WAIT;
                  r_port    <= w_win;
                  r_flushed <= (w_win == PORT_F) && f_flush;
                  r_m_en    <= 1'b1;
                  r_m_we    <= w_sel_we;
                  r_m_addr  <= w_sel_addr;
                  r_m_wdata <= w_sel_wdata;
               end
            end
            WAIT: begin
               if ((r_port == PORT_F) && f_flush)
                  r_flushed <= 1'b1;
               if (w_lat_expired) begin
                  r_state <= RESP;
                  r_m_en  <= 1'b0;
                  r_cap   <= r_m_we ? '0 : m_rdata;
               end
            end
            RESP: begin
               r_state <= IDLE;
               if (f_rvalid)
                  r_f_hold <= r_cap;
               if (l_rvalid)
                  r_l_hold <= r_cap;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_arbiter : directed + randomized bench with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

   localparam int MEM_LAT = 2;
`ifdef IMEM_ARB_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        f_req, f_flush, l_req, l_we;
   logic [31:0] f_addr, l_addr, l_wdata, m_rdata;
   logic        f_gnt, f_rvalid, l_gnt, l_rvalid, m_en, m_we, busy;
   logic [31:0] f_rdata, l_rdata, m_addr, m_wdata;

   logic        f_req_1, f_flush_1, l_req_1, l_we_1;
   logic [31:0] f_addr_1, l_addr_1, l_wdata_1, m_rdata_1;
   logic        f_gnt_1, f_rvalid_1, l_gnt_1, l_rvalid_1, m_en_1, m_we_1, busy_1;
   logic [31:0] f_rdata_1, l_rdata_1, m_addr_1, m_wdata_1;

   imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) u_dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
      .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy));

   imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
      .clock(clock), .reset(reset),
      .f_req(f_req_1), .f_addr(f_addr_1), .f_flush(f_flush_1),
      .f_gnt(f_gnt_1), .f_rvalid(f_rvalid_1), .f_rdata(f_rdata_1),
      .l_req(l_req_1), .l_we(l_we_1), .l_addr(l_addr_1), .l_wdata(l_wdata_1),
      .l_gnt(l_gnt_1), .l_rvalid(l_rvalid_1), .l_rdata(l_rdata_1),
      .m_en(m_en_1), .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1),
      .m_rdata(m_rdata_1), .busy(busy_1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one access in flight, granted at cycle t0,
   // memory busy t0..t0+MEM_LAT, response at t0+MEM_LAT+1.
   int          cyc = 0;
   bit          act_t = 1'b0;
   int          t0 = 0;
   bit          t_port, t_we, t_flushed;
   logic [31:0] t_addr, t_wdata, t_cap;
   bit          last_l = 1'b1;
   logic [31:0] hold_f = '0, hold_l = '0;

   always @(negedge clock) begin : model
      bit          e_fg, e_lg, e_fv, e_lv, e_en, e_we, e_busy, win, bus_chk;
      logic [31:0] e_addr, e_wdata, e_fd, e_ld;
      int          k;
      e_fg = 0; e_lg = 0; e_fv = 0; e_lv = 0; e_en = 0; e_we = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0; bus_chk = 0;
      if (reset !== 1'b1) begin
         act_t = 0; last_l = 1; hold_f = '0; hold_l = '0; bus_chk = 1;
      end else if (!act_t) begin
         if (f_req || l_req) begin
            if (f_req && l_req) win = RR_ON ? !last_l : 1'b0;
            else                win = l_req;
            act_t = 1; t0 = cyc; t_port = win;
            t_we      = win ? l_we : 1'b0;
            t_addr    = win ? l_addr : f_addr;
            t_wdata   = win ? l_wdata : 32'h0;
            t_flushed = !win && f_flush;
            last_l    = win;
            e_fg = !win; e_lg = win; e_en = 1;
         end
      end else begin
         k = cyc - t0;
         e_busy = 1;
         if (k <= MEM_LAT) begin
            e_en = 1;
            if (!t_port && f_flush) t_flushed = 1;
            if (k == MEM_LAT) t_cap = t_we ? 32'h0 : m_rdata;
         end else begin
            if (t_port) begin
               e_lv = 1; hold_l = t_cap;
            end else if (!(t_flushed || f_flush)) begin
               e_fv = 1; hold_f = t_cap;
            end
            act_t = 0;
         end
      end
      if (e_en) begin
         e_we = t_we; e_addr = t_addr; e_wdata = t_wdata; bus_chk = 1;
      end
      e_fd = hold_f;
      e_ld = hold_l;
      chk("mdl_f_gnt", f_gnt, e_fg);
      chk("mdl_l_gnt", l_gnt, e_lg);
      chk("mdl_f_rvalid", f_rvalid, e_fv);
      chk("mdl_l_rvalid", l_rvalid, e_lv);
      chk("mdl_f_rdata", f_rdata, e_fd);
      chk("mdl_l_rdata", l_rdata, e_ld);
      chk("mdl_m_en", m_en, e_en);
      chk("mdl_busy", busy, e_busy);
      if (bus_chk) begin
         chk("mdl_m_we", m_we, e_we);
         chk("mdl_m_addr", m_addr, e_addr);
         chk("mdl_m_wdata", m_wdata, e_wdata);
      end
      cyc++;
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
      m_rdata   = $urandom;
      m_rdata_1 = $urandom;
   endtask

   initial begin
      bit          fg, lg, expl;
      logic [31:0] d1;
      reset = 0; f_req = 0; f_addr = 0; f_flush = 0;
      l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; m_rdata = 0;
      f_req_1 = 0; f_addr_1 = 0; f_flush_1 = 0;
      l_req_1 = 0; l_we_1 = 0; l_addr_1 = 0; l_wdata_1 = 0; m_rdata_1 = 0;
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 1'b0);
      chk("rst_m_en", m_en, 1'b0);
      chk("rst_f_rdata", f_rdata, 32'h0);
      next_cycle(); reset = 1;
      repeat (2) next_cycle();

      // fetch read
      next_cycle(); f_req = 1; f_addr = 32'h10;
      @(negedge clock);
      chk("fr_gnt", f_gnt, 1'b1); chk("fr_m_en", m_en, 1'b1);
      chk("fr_m_addr", m_addr, 32'h10); chk("fr_m_we", m_we, 1'b0);
      next_cycle(); f_req = 0; f_addr = $urandom;
      @(negedge clock);
      chk("fr_m_en_t1", m_en, 1'b1); chk("fr_m_addr_t1", m_addr, 32'h10);
      next_cycle(); m_rdata = 32'h00510093;
      @(negedge clock);
      chk("fr_m_en_t2", m_en, 1'b1);
      next_cycle();
      @(negedge clock);
      chk("fr_rvalid", f_rvalid, 1'b1); chk("fr_rdata", f_rdata, 32'h00510093);
      chk("fr_busy_t3", busy, 1'b1);
      next_cycle();
      @(negedge clock);
      chk("fr_busy_t4", busy, 1'b0); chk("fr_rdata_hold", f_rdata, 32'h00510093);

      // loader write
      next_cycle(); l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'hDEADBEEF;
      @(negedge clock);
      chk("lw_gnt", l_gnt, 1'b1); chk("lw_m_we", m_we, 1'b1);
      chk("lw_m_wdata", m_wdata, 32'hDEADBEEF);
      for (int i = 1; i <= 2; i++) begin
         next_cycle(); l_req = 0; l_we = 0; l_wdata = $urandom;
         @(negedge clock);
         chk("lw_m_we_hold", m_we, 1'b1); chk("lw_m_wdata_hold", m_wdata, 32'hDEADBEEF);
      end
      next_cycle();
      @(negedge clock);
      chk("lw_rvalid", l_rvalid, 1'b1); chk("lw_rdata", l_rdata, 32'h0);
      next_cycle();

      // both requesters held continuously
      next_cycle(); f_req = 1; l_req = 1; l_we = 0; f_addr = 32'h30; l_addr = 32'h34;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) next_cycle();
         @(negedge clock);
         if (i % 4 == 0) begin
            expl = RR_ON ? ((i / 4) % 2 == 1) : 1'b0;
            chk("rr_f_gnt", f_gnt, !expl); chk("rr_l_gnt", l_gnt, expl);
         end else begin
            chk("rr_no_gnt", f_gnt | l_gnt, 1'b0);
         end
      end
      next_cycle(); f_req = 0; l_req = 0;

      // flush during a fetch
      next_cycle(); f_req = 1; f_addr = 32'h40;
      @(negedge clock);
      chk("fl_gnt", f_gnt, 1'b1);
      next_cycle(); f_req = 0; f_flush = 1;
      next_cycle(); f_flush = 0;
      next_cycle();
      @(negedge clock);
      chk("fl_no_rvalid", f_rvalid, 1'b0); chk("fl_busy_t3", busy, 1'b1);
      next_cycle(); f_req = 1; f_addr = 32'h44;
      @(negedge clock);
      chk("fl_busy_t4", busy, 1'b0); chk("fl_regrant", f_gnt, 1'b1);
      next_cycle(); f_req = 0;
      repeat (3) next_cycle();

      // reset during a loader read
      next_cycle(); l_req = 1; l_we = 0; l_addr = 32'h80;
      @(negedge clock);
      chk("rs_l_gnt", l_gnt, 1'b1);
      next_cycle(); l_req = 0; reset = 0;
      @(negedge clock);
      chk("rs_busy", busy, 1'b0); chk("rs_m_en", m_en, 1'b0);
      chk("rs_m_addr", m_addr, 32'h0); chk("rs_f_rdata", f_rdata, 32'h0);
      next_cycle();
      next_cycle(); reset = 1;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         @(negedge clock);
         chk("rs_no_l_rvalid", l_rvalid, 1'b0);
      end
      next_cycle(); f_req = 1; l_req = 1; f_addr = 32'h50; l_addr = 32'h54;
      @(negedge clock);
      chk("rs_f_first", f_gnt, 1'b1); chk("rs_l_not_first", l_gnt, 1'b0);
      next_cycle(); f_req = 0;

      // randomized traffic with withdrawals, flushes and occasional resets
      fg = 0; lg = 0;
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         if (reset == 1'b0) reset = 1;
         else if ($urandom_range(0, 399) == 0) reset = 0;
         if (fg) begin
            f_req = $urandom_range(0, 1); f_addr = $urandom;
         end else if (f_req) begin
            if ($urandom_range(0, 15) == 0) f_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            f_req = 1; f_addr = $urandom;
         end
         if (lg) begin
            l_req = $urandom_range(0, 1); l_we = $urandom_range(0, 1);
            l_addr = $urandom; l_wdata = $urandom;
         end else if (l_req) begin
            if ($urandom_range(0, 15) == 0) l_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            l_req = 1; l_we = $urandom_range(0, 1); l_addr = $urandom; l_wdata = $urandom;
         end
         f_flush = ($urandom_range(0, 7) == 0);
         @(negedge clock);
         fg = f_gnt; lg = l_gnt;
      end
      next_cycle(); reset = 1; f_req = 0; l_req = 0; f_flush = 0;
      repeat (6) next_cycle();

      // single-cycle latency instance
      next_cycle(); f_req_1 = 1; f_addr_1 = 32'h100;
      @(negedge clock);
      chk("l1_gnt_t0", f_gnt_1, 1'b1);
      next_cycle();
      @(negedge clock);
      d1 = m_rdata_1;
      chk("l1_gnt_t1", f_gnt_1, 1'b0); chk("l1_rvalid_t1", f_rvalid_1, 1'b0);
      next_cycle();
      @(negedge clock);
      chk("l1_rvalid_t2", f_rvalid_1, 1'b1); chk("l1_rdata_t2", f_rdata_1, d1);
      chk("l1_gnt_t2", f_gnt_1, 1'b0);
      next_cycle();
      @(negedge clock);
      chk("l1_gnt_t3", f_gnt_1, 1'b1);
      next_cycle(); f_req_1 = 0;
      repeat (4) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
